// File: rtl/mem_responder.sv
// mem_responder: memory-side endpoint of the core's request/response handshake.
//
// It accepts one word request per handshake and performs it on an internal
// word-addressed RAM. The result then passes through a fixed-latency pipeline
// into an in-order response FIFO. Every request, including a write, gets
// exactly one response.
//
// Optional build macro: MEM_RESPONDER_ERR_EN
//   defined   - out-of-range addresses skip the RAM (writes suppressed) and
//               respond with err=1, rdata=0
//   undefined - no range check; the word index wraps so every address aliases
//               into RAM, and resp_err is always 0
//
// Parameters:
//   DEPTH_WORDS  RAM size in 32-bit words (power of two)
//   BASE_ADDR    byte address of word 0
//   LATENCY      cycles from request fire to response valid (1..8)
//   RESP_DEPTH   response FIFO entries = maximum outstanding requests
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_addr/we/be/wdata     byte address (bits [1:0] ignored), write flag,
//                            byte enables, write data
//   resp_valid/resp_ready    response handshake
//   resp_rdata/resp_err      read data (0 for writes/errors), range error
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned RESP_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          acc_err;
    logic          fire;
    logic          push;
    logic          pop;
    resp_t         stage_in;

    assign off = req_addr - BASE_ADDR;
    assign idx = off[AW+1:2];

`ifdef MEM_RESPONDER_ERR_EN
    // A 33-bit limit keeps the compare correct even for a 4 GiB RAM.
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
    assign acc_err = ({1'b0, off} >= LIMIT);
`else
    assign acc_err = 1'b0;
`endif

    // Bits beyond the word index only matter for the optional range check.
    logic unused_bits;
    assign unused_bits = ^{off[31:AW+2], off[1:0]};

    // Gating on !rst keeps a request that arrives while reset is held from
    // touching the RAM.
    assign fire = req_valid && req_ready && !rst;
    assign pop  = resp_valid && resp_ready;

    // ---------------- RAM ----------------
    always_ff @(posedge clk) begin
        if (fire && req_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // The read samples the RAM in the fire cycle, so any write fired earlier
    // is already visible.
    always_comb begin
        stage_in.err   = acc_err;
        stage_in.rdata = (req_we || acc_err) ? 32'h0 : mem[idx];
    end

    // ---------------- latency pipeline ----------------
    logic [LATENCY-1:0] vld_pipe;
    logic [LATENCY:0]   vld_nxt;
    resp_t              dat_pipe [LATENCY];

    assign vld_nxt = {vld_pipe, fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= vld_nxt[LATENCY-1:0];
    end

    always_ff @(posedge clk) begin
        dat_pipe[0] <= stage_in;
        for (int i = 1; i < LATENCY; i++) dat_pipe[i] <= dat_pipe[i-1];
    end

    assign push = vld_pipe[LATENCY-1];

    // ---------------- response FIFO ----------------
    resp_t         fifo [RESP_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt, out_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= dat_pipe[LATENCY-1];
    end

    // out_cnt counts pipeline and FIFO entries together. Capping it at
    // RESP_DEPTH means the FIFO can never overflow, so the pipeline never
    // has to stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({fire, pop})
                2'b10:   out_cnt <= out_cnt + CW'(1);
                2'b01:   out_cnt <= out_cnt - CW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign req_ready  = (out_cnt < CW'(RESP_DEPTH));
    assign resp_valid = (fifo_cnt != '0);
    // Gate the outputs so they read 0 whenever no response is presented.
    assign resp_rdata = resp_valid ? fifo[rd_ptr].rdata : 32'h0;
    assign resp_err   = resp_valid ? fifo[rd_ptr].err   : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam int unsigned D    = 4096;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int unsigned L    = 2;
    localparam int unsigned RD   = 4;
`ifdef MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        resp_valid, resp_ready = 1, resp_err;
    logic [31:0] resp_rdata;

    mem_responder #(.DEPTH_WORDS(D), .BASE_ADDR(BASE), .LATENCY(L), .RESP_DEPTH(RD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] rdata; bit err; int due; } exp_t;
    typedef struct { string name; req_t rq; logic [31:0] exp_rdata; bit exp_err; } vec_t;

    req_t        pend [$];
    exp_t        exp_q [$];
    logic [31:0] model_mem [int];
    int          cyc = 0, n_fire = 0, n_resp = 0;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    vec_t        tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t mkr(bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
        req_t r;
        r.we = we; r.addr = a; r.be = be; r.wdata = wd;
        return r;
    endfunction

    function automatic vec_t mkv(string n, req_t r, logic [31:0] er, bit ee);
        vec_t v;
        v.name = n; v.rq = r; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Reference behaviour: offset/range/alias arithmetic on a word dictionary,
    // and an in-order queue of responses, each with the cycle it becomes due.
    task automatic model_accept(input req_t r);
        bit [31:0]   o;
        bit          err;
        int          idx;
        logic [31:0] cur;
        exp_t        e;
        o   = r.addr - BASE;
        err = ERR_EN && (o >= 32'(D * 4));
        idx = int'((o >> 2) % D);
        cur = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        e.err = err;
        e.due = cyc + L;
        e.rdata = 32'h0;
        if (r.we) begin
            if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (r.be[b]) cur[8*b +: 8] = r.wdata[8*b +: 8];
                model_mem[idx] = cur;
            end
        end else if (!err) begin
            e.rdata = cur;
        end
        exp_q.push_back(e);
    endtask

    // One clock cycle. Inputs are driven and handshakes sampled before the
    // edge; outputs are checked 1 ns after it.
    task automatic step();
        bit          fire, pop, hold;
        logic [31:0] h_rdata;
        logic        h_err;
        req_t        r;
        if (pend.size() > 0) begin
            r = pend[0];
            req_valid = 1; req_we = r.we; req_addr = r.addr; req_be = r.be; req_wdata = r.wdata;
        end else begin
            req_valid = 0; req_we = 0; req_addr = 0; req_be = 0; req_wdata = 0;
        end
        #1;
        fire    = req_valid && req_ready;
        pop     = resp_valid && resp_ready;
        hold    = resp_valid && !resp_ready;
        h_rdata = resp_rdata;
        h_err   = resp_err;
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("resp_rdata", resp_rdata, exp_q[0].rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                last_rdata = resp_rdata;
                last_err   = resp_err;
                exp_q.pop_front();
                n_resp++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (fire) begin
            model_accept(pend[0]);
            pend.pop_front();
            n_fire++;
        end
        chk("resp_valid", 32'(resp_valid), 32'(exp_q.size() > 0 && exp_q[0].due <= cyc));
        chk("req_ready", 32'(req_ready), 32'(exp_q.size() < RD));
        if (hold) begin
            chk("hold_rdata", resp_rdata, h_rdata);
            chk("hold_err", 32'(resp_err), 32'(h_err));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (pend.size() == 0 && exp_q.size() == 0) break;
            step();
        end
        chk("drain_timeout", 32'(pend.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        int f0, r0;
        req_t r;

        // ---- reset state ----
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---- table-driven single transactions ----
        tbl[0]  = mkv("wr_w0",   mkr(1, BASE,               4'hF, 32'hDEADBEEF), 32'h0, 0);
        tbl[1]  = mkv("rd_w0",   mkr(0, BASE,               4'hF, 32'h0),        32'hDEADBEEF, 0);
        tbl[2]  = mkv("wr_w4",   mkr(1, BASE + 32'h10,      4'hF, 32'hAAAAAAAA), 32'h0, 0);
        tbl[3]  = mkv("wr_be",   mkr(1, BASE + 32'h10,      4'b0101, 32'h11223344), 32'h0, 0);
        tbl[4]  = mkv("rd_be",   mkr(0, BASE + 32'h10,      4'h0, 32'h0),        32'hAA22AA44, 0);
        tbl[5]  = mkv("rd_low",  mkr(0, BASE + 32'h13,      4'h0, 32'h0),        32'hAA22AA44, 0);
        tbl[6]  = mkv("wr_last", mkr(1, BASE + 32'((D-1)*4), 4'hF, 32'hCAFEF00D), 32'h0, 0);
        tbl[7]  = mkv("wr_oor",  mkr(1, 32'h7FFFFFFC,       4'hF, 32'h12345678), 32'h0, ERR_EN);
        tbl[8]  = mkv("rd_last", mkr(0, BASE + 32'((D-1)*4), 4'h0, 32'h0),
                      ERR_EN ? 32'hCAFEF00D : 32'h12345678, 0);
        tbl[9]  = mkv("rd_above", mkr(0, BASE + 32'(D*4),   4'h0, 32'h0),
                      ERR_EN ? 32'h0 : 32'hDEADBEEF, ERR_EN);
        tbl[10] = mkv("rd_below", mkr(0, 32'h7FFFFFFC,      4'h0, 32'h0),
                      ERR_EN ? 32'h0 : 32'h12345678, ERR_EN);
        resp_ready = 1;
        for (int i = 0; i < 11; i++) begin
            r0 = n_resp;
            pend.push_back(tbl[i].rq);
            drain();
            chk({tbl[i].name, "_count"}, 32'(n_resp - r0), 32'd1);
            chk({tbl[i].name, "_rdata"}, last_rdata, tbl[i].exp_rdata);
            chk({tbl[i].name, "_err"}, 32'(last_err), 32'(tbl[i].exp_err));
        end

        // ---- preload a 16-word window ----
        for (int w = 0; w < 16; w++)
            pend.push_back(mkr(1, BASE + 32'(4*w), 4'hF, 32'h5000_0000 + 32'(w * 32'h0101)));
        drain();

        // ---- backpressure and fire-with-pop at full occupancy ----
        resp_ready = 0;
        f0 = n_fire;
        r0 = n_resp;
        for (int w = 0; w < 6; w++) pend.push_back(mkr(0, BASE + 32'(4*w), 4'h0, 32'h0));
        repeat (6) step();
        chk("bp_accepted", 32'(n_fire - f0), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        repeat (4) step();
        chk("bp_still_full", 32'(req_ready), 32'd0);
        chk("bp_resp_waiting", 32'(resp_valid), 32'd1);
        resp_ready = 1;
        chk("pop_cycle_ready", 32'(req_ready), 32'd0);
        step();
        chk("after_pop_ready", 32'(req_ready), 32'd1);
        f0 = n_fire;
        step();
        chk("fire_pop_fired", 32'(n_fire - f0), 32'd1);
        chk("fire_pop_ready", 32'(req_ready), 32'd1);
        drain();
        chk("bp_resp_total", 32'(n_resp - r0), 32'd6);

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            if (pend.size() < 2 && ($urandom % 3) != 0) begin
                int unsigned w, sel;
                logic [31:0] a;
                w   = $urandom % 16;
                sel = $urandom % 8;
                if (sel == 0)      a = BASE + 32'(D*4) + 32'(4*w);
                else if (sel == 1) a = BASE - 32'(D*4) + 32'(4*w);
                else               a = BASE + 32'(4*w);
                a[1:0] = 2'($urandom);
                pend.push_back(mkr(1'($urandom), a, 4'($urandom), $urandom));
            end
            resp_ready = ($urandom % 10) < 7;
            step();
        end
        resp_ready = 1;
        drain();

        // ---- reset mid-flight ----
        pend.push_back(mkr(0, BASE + 32'h4, 4'h0, 32'h0));
        pend.push_back(mkr(0, BASE + 32'h8, 4'h0, 32'h0));
        step();
        step();
        step();
        chk("mid_resp_before_rst", 32'(resp_valid), 32'd1);
        rst = 1;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        pend.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        repeat (5) step();
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        // A stale outstanding count would admit fewer than RD requests here.
        resp_ready = 0;
        f0 = n_fire;
        for (int w = 0; w < 5; w++) pend.push_back(mkr(0, BASE + 32'(4*w), 4'h0, 32'h0));
        repeat (8) step();
        chk("post_rst_accept", 32'(n_fire - f0), 32'(RD));
        resp_ready = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
